panda_ram_2p: RTL and testbench
===============================

// Module: panda_ram_2p
// PURPOSE
//   Simple dual-port RAM: port A read/write with byte-wide write enables, port B read-only.
//   Both ports share one clock and return data with a valid strobe and a fixed latency.
//   Used where instruction fetch and load/store, or a core and a debug/DMA reader, share one array.
//   Adds a response pipeline, same-address collision control, out-of-range handling and reset.
// PARAMETERS
//   DataWidth   32         word width in bits; multiple of 8
//   Depth       1024       number of words; any value >= 2 (AddrWidth = $clog2(Depth))
//   OutputReg   1'b1       1: extra output register stage (latency 2); 0: latency 1
//   WriteFirst  1'b1       A-write/B-read same-address collision: 1 = B gets new data, 0 = old data
//   InitFile    ""         if non-empty, $readmemh preload at time 0; otherwise contents undefined
// PORTS
//   clk_i        in   1              clock, all logic on rising edge
//   rst_ni       in   1              synchronous active-low reset
//   a_req_i      in   1              port A request this cycle
//   a_we_i       in   DataWidth/8    byte write enables; any bit set = write, all zero = read
//   a_addr_i     in   AddrWidth      port A word address
//   a_wdata_i    in   DataWidth      port A write data
//   a_rvalid_o   out  1              port A read response valid (one-cycle pulse per read)
//   a_rdata_o    out  DataWidth      port A read data
//   b_req_i      in   1              port B read request
//   b_addr_i     in   AddrWidth      port B word address
//   b_rvalid_o   out  1              port B read response valid
//   b_rdata_o    out  DataWidth      port B read data
// BEHAVIOUR
//   - No backpressure: every request accepted in the cycle it is presented; one request/port/cycle.
//   - Latency: response for a request at edge N appears after edge N+1 (OutputReg=0) or N+2 (=1).
//   - rvalid pipelines: per port, shift register of depth 1 or 2; requests in order, never dropped.
//   - Writes produce no response on a_rvalid_o; only enabled bytes updated, others keep old value.
//   - a_rdata_o/b_rdata_o update only when matching rvalid asserts; otherwise hold last value.
//   - Reset (rst_ni low at edge): rvalid pipelines and rdata registers cleared to 0; in-flight
//     responses discarded; requests sampled in that cycle ignored (no write, no response).
//   - Memory array is never reset; contents persist across reset.
//   - Out of range (addr >= Depth, Depth not power of 2): write ignored; read responds with rvalid=1,
//     rdata=0.
//   - Collision, A write and B read same address same edge:
//       WriteFirst=1: B data = bytewise merge (enabled bytes from a_wdata_i, rest old contents).
//       WriteFirst=0: B data = contents before the write.
//   - Read after write on any port at a later edge always sees the written data.
//   - A read and B read to same address same cycle: both respond with identical data.
//   - rst_ni deasserted: first request accepted on the first edge with rst_ni high.
// TESTING
//   1 Reset: hold rst_ni=0 3 cycles with a_req_i=b_req_i=1 -> rvalid_o=0, rdata_o=0; no mem change.
//   2 OutputReg=1: A write 0xDEADBEEF @5 (we=4'hF), then A read @5 -> a_rvalid_o 2 cycles after the
//     read edge, a_rdata_o=0xDEADBEEF, exactly one rvalid pulse.
//   3 Byte enables: @7=0x11223344, write we=4'b0101 data 0xAABBCCDD -> read @7 returns 0x11BB33DD.
//   4 Collision: @9=0x0, same-edge A write 0x12345678 (we=4'hF) and B read @9 -> B gets 0x12345678
//     with WriteFirst=1, 0x00000000 with WriteFirst=0.
//   5 Back-to-back: B reads @0..@15 one per cycle -> 16 consecutive rvalid pulses, in order, correct.
//   6 Reset mid-flight: B read issued, rst_ni=0 next edge -> no b_rvalid_o pulse for that read.

Source files
------------

// File: rtl/panda_ram_2p.sv
// Simple dual-port RAM: port A read/write with byte enables, port B read-only.
// Fixed-latency responses with valid strobes, collision control and out-of-range handling.
module panda_ram_2p #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 1024,
  parameter bit          OutputReg  = 1'b1,
  parameter bit          WriteFirst = 1'b1,
  parameter string       InitFile   = "",
  localparam int unsigned AddrWidth = $clog2(Depth),
  localparam int unsigned NumBytes  = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_req_i,
  input  logic [NumBytes-1:0]  a_we_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic                 a_rvalid_o,
  output logic [DataWidth-1:0] a_rdata_o,
  input  logic                 b_req_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  output logic                 b_rvalid_o,
  output logic [DataWidth-1:0] b_rdata_o
);

  logic [DataWidth-1:0] mem [Depth];

  logic                 a_in_range, b_in_range;
  logic                 a_wr, a_rd, collide;
  logic [DataWidth-1:0] a_word, b_word;

  assign a_in_range = 32'(a_addr_i) < Depth;
  assign b_in_range = 32'(b_addr_i) < Depth;
  assign a_wr       = rst_ni && a_req_i && (|a_we_i) && a_in_range;
  assign a_rd       = a_req_i && !(|a_we_i);
  assign collide    = a_wr && b_req_i && (a_addr_i == b_addr_i);
  assign a_word     = a_in_range ? mem[a_addr_i] : '0;

  // On a collision the write-first variant forwards the enabled write bytes to port B.
  always_comb begin
    b_word = b_in_range ? mem[b_addr_i] : '0;
    if (WriteFirst && collide) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (a_we_i[i]) b_word[8*i +: 8] = a_wdata_i[8*i +: 8];
      end
    end
  end

  // Array is never reset; a_wr already excludes reset cycles and out-of-range addresses.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (a_wr && a_we_i[i]) mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
    end
  end

  logic                 a_v1_q, b_v1_q;
  logic [DataWidth-1:0] a_d1_q, b_d1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_rd;
      b_v1_q <= b_req_i;
      if (a_rd)    a_d1_q <= a_word;
      if (b_req_i) b_d1_q <= b_word;
    end
  end

  if (OutputReg) begin : g_oreg
    logic                 a_v2_q, b_v2_q;
    logic [DataWidth-1:0] a_d2_q, b_d2_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end

    assign a_rvalid_o = a_v2_q;
    assign a_rdata_o  = a_d2_q;
    assign b_rvalid_o = b_v2_q;
    assign b_rdata_o  = b_d2_q;
  end else begin : g_noreg
    assign a_rvalid_o = a_v1_q;
    assign a_rdata_o  = a_d1_q;
    assign b_rvalid_o = b_v1_q;
    assign b_rdata_o  = b_d1_q;
  end

endmodule

// File: tb/tb_panda_ram_2p.sv
// Self-checking bench for panda_ram_2p: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_panda_ram_2p;

  localparam int unsigned DW         = 32;
  localparam int unsigned Depth      = 20;
  localparam int unsigned AW         = $clog2(Depth);
  localparam int unsigned NB         = DW / 8;
  localparam bit          OutputReg  = 1'b1;
  localparam bit          WriteFirst = 1'b1;
  localparam int          Extra      = OutputReg ? 1 : 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req;
  logic [NB-1:0] a_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  panda_ram_2p #(
    .DataWidth (DW),
    .Depth     (Depth),
    .OutputReg (OutputReg),
    .WriteFirst(WriteFirst),
    .InitFile  ("")
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_req_i   (a_req),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rvalid_o(a_rvalid),
    .a_rdata_o (a_rdata),
    .b_req_i   (b_req),
    .b_addr_i  (b_addr),
    .b_rvalid_o(b_rvalid),
    .b_rdata_o (b_rdata)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          qa[$];
  rsp_t          qb[$];
  logic [DW-1:0] ref_mem [Depth];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int            ecnt   = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd,
                                          logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  task automatic chk_bit(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  task automatic drive(logic ar, logic [NB-1:0] we, logic [AW-1:0] aa, logic [DW-1:0] wd,
                       logic br, logic [AW-1:0] ba);
    a_req   = ar;
    a_we    = we;
    a_addr  = aa;
    a_wdata = wd;
    b_req   = br;
    b_addr  = ba;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // One clock: apply the model to the inputs sampled at this edge, then check both ports.
  // A request sampled at edge k is due to be visible just after edge k + Extra.
  task automatic tick();
    logic [DW-1:0] ad, bd;
    logic          a_wr;
    @(posedge clk);
    ecnt++;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      a_wr = a_req && (a_we != '0) && (a_addr < Depth);
      if (b_req) begin
        bd = (b_addr < Depth) ? ref_mem[b_addr] : '0;
        if (WriteFirst && a_wr && (a_addr == b_addr)) bd = merge(bd, a_wdata, a_we);
        qb.push_back('{due: ecnt + Extra, data: bd});
      end
      if (a_req && a_we == '0) begin
        ad = (a_addr < Depth) ? ref_mem[a_addr] : '0;
        qa.push_back('{due: ecnt + Extra, data: ad});
      end
      if (a_wr) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_we);
    end
    #1;
    if (qa.size() > 0 && qa[0].due == ecnt) begin
      last_a = qa[0].data;
      void'(qa.pop_front());
      chk_bit("a_rvalid", a_rvalid, 1'b1);
    end else begin
      chk_bit("a_rvalid", a_rvalid, 1'b0);
    end
    chk("a_rdata", a_rdata, last_a);
    if (qb.size() > 0 && qb[0].due == ecnt) begin
      last_b = qb[0].data;
      void'(qb.pop_front());
      chk_bit("b_rvalid", b_rvalid, 1'b1);
    end else begin
      chk_bit("b_rvalid", b_rvalid, 1'b0);
    end
    chk("b_rdata", b_rdata, last_b);
  endtask

  initial begin
    // Reset held with both ports requesting: no responses, outputs zero.
    rst_n = 1'b0;
    drive(1'b1, '1, 5'd3, 32'hBAD0_BAD0, 1'b1, 5'd3);
    repeat (3) tick();
    chk_bit("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rdata", b_rdata, '0);

    // Preload every word so the model knows the full array.
    rst_n = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      drive(1'b1, '1, AW'(i), $urandom(), 1'b0, '0);
      tick();
    end

    // Full write then read at word 5.
    drive(1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF, 1'b0, '0);
    tick();
    drive(1'b1, 4'h0, 5'd5, '0, 1'b0, '0);
    tick();
    idle();
    tick();
    chk_bit("rd5_rvalid", a_rvalid, 1'b1);
    chk("rd5_rdata", a_rdata, 32'hDEAD_BEEF);
    tick();
    chk_bit("rd5_single_pulse", a_rvalid, 1'b0);

    // Partial byte write.
    drive(1'b1, 4'hF, 5'd7, 32'h1122_3344, 1'b0, '0);
    tick();
    drive(1'b1, 4'b0101, 5'd7, 32'hAABB_CCDD, 1'b0, '0);
    tick();
    drive(1'b1, 4'h0, 5'd7, '0, 1'b0, '0);
    tick();
    idle();
    tick();
    chk("byte_en", a_rdata, 32'h11BB_33DD);

    // Same-edge A write / B read collision.
    drive(1'b1, 4'hF, 5'd9, 32'h0, 1'b0, '0);
    tick();
    drive(1'b1, 4'hF, 5'd9, 32'h1234_5678, 1'b1, 5'd9);
    tick();
    idle();
    tick();
    chk_bit("collide_rvalid", b_rvalid, 1'b1);
    chk("collide_rdata", b_rdata, WriteFirst ? 32'h1234_5678 : 32'h0);

    // Back-to-back B reads over 0..15.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
      tick();
    end
    idle();
    repeat (3) tick();

    // Top in-range word and out-of-range address; A and B reading the same word.
    drive(1'b1, 4'hF, 5'd19, 32'hCAFE_F00D, 1'b0, '0);
    tick();
    drive(1'b1, 4'hF, 5'd25, 32'h5555_AAAA, 1'b1, 5'd25);
    tick();
    drive(1'b1, 4'h0, 5'd25, '0, 1'b1, 5'd19);
    tick();
    idle();
    tick();
    chk_bit("oor_rvalid", a_rvalid, 1'b1);
    chk("oor_rdata", a_rdata, '0);
    chk("top_word", b_rdata, 32'hCAFE_F00D);
    drive(1'b1, 4'h0, 5'd19, '0, 1'b1, 5'd19);
    tick();
    idle();
    tick();
    chk("same_addr_a", a_rdata, 32'hCAFE_F00D);
    chk("same_addr_b", b_rdata, 32'hCAFE_F00D);

    // Reset while a B read is in flight; a write during reset must not land.
    drive(1'b0, '0, '0, '0, 1'b1, 5'd4);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4);
    tick();
    chk_bit("rst_flight_b", b_rvalid, 1'b0);
    rst_n = 1'b1;
    idle();
    tick();
    chk_bit("rst_flight_b2", b_rvalid, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd4);
    tick();
    idle();
    repeat (2) tick();

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? NB'($urandom()) : '0,
            AW'($urandom_range(0, 2**AW - 1)),
            $urandom(),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 2**AW - 1)));
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
